// File: rtl/updslow_pkg.sv
// Shared constants, FSM state encoding and helpers for the slow-path IQ/noise packer.
package updslow_pkg;

  localparam int unsigned SAMPLE_W          = 16;
  localparam int unsigned WORD_W            = 128;
  localparam int unsigned NOISE_LANES       = 8;
  localparam int unsigned IQ_BEATS_PER_WORD = 2;
  localparam int unsigned IQ_LANES_PER_BEAT = NOISE_LANES / IQ_BEATS_PER_WORD;

  typedef enum logic [7:0] {
    StIdle     = 8'b0000_0001,
    StUserRun  = 8'b0000_0010,
    StFlush    = 8'b0000_0100,
    StUserComp = 8'b0000_1000
  } state_e;

  // Two REs per beat; the count sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add2(input logic [15:0] v);
    logic [16:0] s;
    s = {1'b0, v} + 17'd2;
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/updslow_word_packer.sv
// Packs LanesPerWrite 16-bit lanes per push into a 128-bit word; owns the registered
// FIFO write port and the flush of a partially filled word.
module updslow_word_packer
  import updslow_pkg::*;
#(
  parameter int unsigned LanesPerWrite = 1,
  parameter bit          PadRepeat     = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clr_i,
  input  logic                              push_i,
  input  logic [SAMPLE_W*LanesPerWrite-1:0] push_data_i,
  input  logic                              flush_i,
  input  logic                              full_i,
  output logic                              pending_o,
  output logic                              wr_en_o,
  output logic [WORD_W-1:0]                 wr_data_o
);

  localparam int unsigned PushW   = SAMPLE_W * LanesPerWrite;
  localparam int unsigned Slots   = WORD_W / PushW;
  localparam int unsigned IdxW    = $clog2(Slots);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Slots - 1);

  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [WORD_W-1:0] pad_word;
  logic [PushW-1:0]  last_q, last_d;
  logic              wr_en_q, wr_en_d;

  // Unfilled slots are already zero in word_q; repeat mode overwrites them.
  always_comb begin
    pad_word = word_q;
    for (int s = 0; s < int'(Slots); s++) begin
      if (PadRepeat && (s >= int'(idx_q))) begin
        pad_word[s*PushW +: PushW] = last_q;
      end
    end
  end

  always_comb begin
    idx_d     = idx_q;
    word_d    = word_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    if (clr_i) begin
      idx_d  = '0;
      word_d = '0;
      last_d = '0;
    end else if (push_i) begin
      word_d[idx_q*PushW +: PushW] = push_data_i;
      last_d = push_data_i;
      if (idx_q == LastIdx) begin
        wr_en_d   = 1'b1;
        wr_data_d = word_d;
        idx_d     = '0;
        word_d    = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (flush_i && (idx_q != '0) && !full_i) begin
      wr_en_d   = 1'b1;
      wr_data_d = pad_word;
      idx_d     = '0;
      word_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q     <= '0;
      word_q    <= '0;
      last_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      idx_q     <= idx_d;
      word_q    <= word_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign pending_o = (idx_q != '0);
  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/updslow_iq_noise_packer.sv
// Producer side of the slow-path IQ/noise FIFO pair: per-user framing, packing and flush.
// Define UPDSLOW_NOISE_PAD_REPEAT_EN to pad a flushed noise word with the last sample.
module updslow_iq_noise_packer
  import updslow_pkg::*;
(
  input  logic                i_core_clk,
  input  logic                i_rx_rstn,
  input  logic                i_user_start,
  input  logic [15:0]         i_cur_user_re_amounts,
  input  logic                i_data_strobe,
  input  logic [15:0]         i_re0_data_i,
  input  logic [15:0]         i_re0_data_q,
  input  logic [15:0]         i_re1_data_i,
  input  logic [15:0]         i_re1_data_q,
  input  logic                i_noise_strobe,
  input  logic [15:0]         i_noise_data,
  input  logic                IQ_FIFO_Full,
  input  logic                Noise_FIFO_Full,
  output logic                o_ready,
  output logic                IQ_FIFO_Write_Enable,
  output logic                Noise_FIFO_Write_Enable,
  output logic [WORD_W-1:0]   IQ_Data_SUM,
  output logic [WORD_W-1:0]   Noise_Data_SUM,
  output logic                o_user_done,
  output logic                o_drop_err
);

`ifdef UPDSLOW_NOISE_PAD_REPEAT_EN
  localparam bit NoisePadRepeat = 1'b1;
`else
  localparam bit NoisePadRepeat = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [15:0] re_amt_q, re_amt_d;
  logic [15:0] re_cnt_q, re_cnt_d;
  logic [15:0] cnt_next;
  logic        flush_first_q, flush_first_d;
  logic        drop_err_q, drop_err_d;
  logic        iq_push, noise_push, user_clr, in_flush;
  logic        iq_pending, noise_pending;

  assign o_ready     = (state_q == StUserRun) & ~IQ_FIFO_Full & ~Noise_FIFO_Full;
  assign iq_push     = i_data_strobe & o_ready;
  assign noise_push  = i_noise_strobe & o_ready;
  assign user_clr    = (state_q == StIdle) & i_user_start;
  assign in_flush    = (state_q == StFlush);
  assign cnt_next    = sat_add2(re_cnt_q);
  assign o_user_done = (state_q == StUserComp);
  assign o_drop_err  = drop_err_q;

  // The first FLUSH cycle is always spent, so a word completed on entry is already out
  // and any partial word is issued before USERCOMP can be reached.
  always_comb begin
    state_d       = state_q;
    re_amt_d      = re_amt_q;
    re_cnt_d      = re_cnt_q;
    flush_first_d = 1'b0;
    drop_err_d    = drop_err_q | ((i_data_strobe | i_noise_strobe) & ~o_ready);
    unique case (state_q)
      StIdle: begin
        if (i_user_start) begin
          re_amt_d = i_cur_user_re_amounts;
          re_cnt_d = '0;
          state_d  = (i_cur_user_re_amounts == '0) ? StUserComp : StUserRun;
        end
      end
      StUserRun: begin
        if (iq_push) begin
          re_cnt_d = cnt_next;
          if (cnt_next >= re_amt_q) begin
            state_d       = StFlush;
            flush_first_d = 1'b1;
          end
        end
      end
      StFlush: begin
        if (!flush_first_q && !iq_pending && !noise_pending) state_d = StUserComp;
      end
      StUserComp: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q       <= StIdle;
      re_amt_q      <= '0;
      re_cnt_q      <= '0;
      flush_first_q <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      re_amt_q      <= re_amt_d;
      re_cnt_q      <= re_cnt_d;
      flush_first_q <= flush_first_d;
      drop_err_q    <= drop_err_d;
    end
  end

  updslow_word_packer #(
    .LanesPerWrite(IQ_LANES_PER_BEAT),
    .PadRepeat    (1'b0)
  ) u_iq_packer (
    .clk_i      (i_core_clk),
    .rst_ni     (i_rx_rstn),
    .clr_i      (user_clr),
    .push_i     (iq_push),
    .push_data_i({i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i}),
    .flush_i    (in_flush),
    .full_i     (IQ_FIFO_Full),
    .pending_o  (iq_pending),
    .wr_en_o    (IQ_FIFO_Write_Enable),
    .wr_data_o  (IQ_Data_SUM)
  );

  updslow_word_packer #(
    .LanesPerWrite(1),
    .PadRepeat    (NoisePadRepeat)
  ) u_noise_packer (
    .clk_i      (i_core_clk),
    .rst_ni     (i_rx_rstn),
    .clr_i      (user_clr),
    .push_i     (noise_push),
    .push_data_i(i_noise_data),
    .flush_i    (in_flush),
    .full_i     (Noise_FIFO_Full),
    .pending_o  (noise_pending),
    .wr_en_o    (Noise_FIFO_Write_Enable),
    .wr_data_o  (Noise_Data_SUM)
  );

endmodule

// File: tb/tb_updslow_iq_noise_packer.sv
// Directed bench for updslow_iq_noise_packer: table of user transactions plus stall and
// async-reset sequences.
module tb_updslow_iq_noise_packer;

  logic         clk;
  logic         rst_n;
  logic         user_start;
  logic [15:0]  re_amounts;
  logic         data_strobe;
  logic [15:0]  re0_i, re0_q, re1_i, re1_q;
  logic         noise_strobe;
  logic [15:0]  noise_data;
  logic         iq_full, nz_full;
  logic         ready;
  logic         iq_we, nz_we;
  logic [127:0] iq_data, nz_data;
  logic         user_done;
  logic         drop_err;

  updslow_iq_noise_packer dut (
    .i_core_clk             (clk),
    .i_rx_rstn              (rst_n),
    .i_user_start           (user_start),
    .i_cur_user_re_amounts  (re_amounts),
    .i_data_strobe          (data_strobe),
    .i_re0_data_i           (re0_i),
    .i_re0_data_q           (re0_q),
    .i_re1_data_i           (re1_i),
    .i_re1_data_q           (re1_q),
    .i_noise_strobe         (noise_strobe),
    .i_noise_data           (noise_data),
    .IQ_FIFO_Full           (iq_full),
    .Noise_FIFO_Full        (nz_full),
    .o_ready                (ready),
    .IQ_FIFO_Write_Enable   (iq_we),
    .Noise_FIFO_Write_Enable(nz_we),
    .IQ_Data_SUM            (iq_data),
    .Noise_Data_SUM         (nz_data),
    .o_user_done            (user_done),
    .o_drop_err             (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] W_FIRST = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [127:0] W_FULL1 = 128'h0010_000F_000E_000D_000C_000B_000A_0009;
  localparam logic [127:0] W_HALF1 = 128'h0000_0000_0000_0000_000C_000B_000A_0009;
  localparam logic [127:0] W_LAST3 = 128'h0020_001F_001E_001D_001C_001B_001A_0019;
  localparam logic [127:0] W_HALF0 = 128'h0000_0000_0000_0000_0004_0003_0002_0001;
  localparam logic [127:0] NZ_FULL = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
`ifdef UPDSLOW_NOISE_PAD_REPEAT_EN
  localparam logic [127:0] NZ_ABC  = 128'h000C_000C_000C_000C_000C_000C_000B_000A;
  localparam logic [127:0] NZ_55   = 128'h0055_0055_0055_0055_0055_0055_0055_0055;
`else
  localparam logic [127:0] NZ_ABC  = 128'h0000_0000_0000_0000_0000_000C_000B_000A;
  localparam logic [127:0] NZ_55   = 128'h0000_0000_0000_0000_0000_0000_0000_0055;
`endif

  typedef struct {
    logic [15:0]  re_amt;
    int           n_beats;
    int           n_noise;
    logic [15:0]  noise_base;
    int           exp_iq_wr;
    logic [127:0] exp_iq_first;
    logic [127:0] exp_iq_last;
    int           exp_nz_wr;
    logic [127:0] exp_nz_last;
    int           exp_gap;   // cycles from last write to o_user_done; -1 = no writes
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [127:0] iq_q[$];
  logic [127:0] nz_q[$];
  int           iq_cyc[$];
  int           nz_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (iq_we) begin
      iq_q.push_back(iq_data);
      iq_cyc.push_back(cyc);
    end
    if (nz_we) begin
      nz_q.push_back(nz_data);
      nz_cyc.push_back(cyc);
    end
    if (user_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    iq_q.delete();
    nz_q.delete();
    iq_cyc.delete();
    nz_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic drive_beat(input int b);
    data_strobe = 1'b1;
    re0_i = 16'(4 * b + 1);
    re0_q = 16'(4 * b + 2);
    re1_i = 16'(4 * b + 3);
    re1_q = 16'(4 * b + 4);
  endtask

  task automatic idle_inputs();
    user_start   = 1'b0;
    data_strobe  = 1'b0;
    noise_strobe = 1'b0;
  endtask

  task automatic start_user(input logic [15:0] amt);
    user_start = 1'b1;
    re_amounts = amt;
    step();
    user_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int t = 0; t < 30 && done_cnt == 0; t++) step();
    repeat (3) step();
    chk({name, " done_count"}, 128'(done_cnt), 128'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string n;
    int    lastw;
    n = $sformatf("vec%0d", idx);
    clear_log();
    start_user(v.re_amt);
    for (int i = 0; i < v.n_beats; i++) begin
      drive_beat(i);
      noise_strobe = (i < v.n_noise);
      noise_data   = v.noise_base + 16'(i);
      #1;
      chk({n, " ready"}, 128'(ready), 128'd1);
      step();
    end
    idle_inputs();
    wait_done(n);
    chk({n, " iq_writes"}, 128'(iq_q.size()), 128'(v.exp_iq_wr));
    chk({n, " nz_writes"}, 128'(nz_q.size()), 128'(v.exp_nz_wr));
    if (v.exp_iq_wr > 0 && iq_q.size() > 0) begin
      chk({n, " iq_first"}, iq_q[0], v.exp_iq_first);
      chk({n, " iq_last"}, iq_q[iq_q.size()-1], v.exp_iq_last);
    end
    if (v.exp_nz_wr > 0 && nz_q.size() > 0) chk({n, " nz_last"}, nz_q[nz_q.size()-1], v.exp_nz_last);
    if (v.exp_gap >= 0) begin
      lastw = 0;
      if (iq_cyc.size() > 0) lastw = iq_cyc[iq_cyc.size()-1];
      if (nz_cyc.size() > 0 && nz_cyc[nz_cyc.size()-1] > lastw) lastw = nz_cyc[nz_cyc.size()-1];
      chk({n, " done_gap"}, 128'(done_cyc - lastw), 128'(v.exp_gap));
    end
    chk({n, " drop_err"}, 128'(drop_err), 128'd0);
  endtask

  task automatic chk_outputs_zero(input string n);
    chk({n, " iq_we"}, 128'(iq_we), 128'd0);
    chk({n, " nz_we"}, 128'(nz_we), 128'd0);
    chk({n, " iq_data"}, iq_data, 128'd0);
    chk({n, " nz_data"}, nz_data, 128'd0);
    chk({n, " ready"}, 128'(ready), 128'd0);
    chk({n, " done"}, 128'(user_done), 128'd0);
    chk({n, " drop_err"}, 128'(drop_err), 128'd0);
  endtask

  initial begin
    vecs[0] = '{16'd8,  4, 0, 16'h0000, 2, W_FIRST, W_FULL1, 0, 128'd0,  2};
    vecs[1] = '{16'd6,  3, 3, 16'h000A, 2, W_FIRST, W_HALF1, 1, NZ_ABC,  1};
    vecs[2] = '{16'd16, 8, 8, 16'h0010, 4, W_FIRST, W_LAST3, 1, NZ_FULL, 2};
    vecs[3] = '{16'd1,  1, 1, 16'h0055, 1, W_HALF0, W_HALF0, 1, NZ_55,   1};
    vecs[4] = '{16'd0,  0, 0, 16'h0000, 0, 128'd0,  128'd0,  0, 128'd0, -1};

    rst_n = 1'b1;
    idle_inputs();
    re_amounts = '0;
    re0_i = '0; re0_q = '0; re1_i = '0; re1_q = '0;
    noise_data = '0;
    iq_full = 1'b0;
    nz_full = 1'b0;
    #2 rst_n = 1'b0;
    #5;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // FIFO full mid-user: no acceptance, dropped strobe flagged, held data intact.
    clear_log();
    start_user(16'd8);
    drive_beat(0);
    step();
    data_strobe = 1'b0;
    iq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        data_strobe = 1'b1;
        re0_i = 16'hDEAD; re0_q = 16'hBEEF; re1_i = 16'hDEAD; re1_q = 16'hBEEF;
      end
      #1;
      chk($sformatf("stall ready%0d", i), 128'(ready), 128'd0);
      step();
    end
    chk("stall no_writes", 128'(iq_q.size()), 128'd0);
    iq_full = 1'b0;
    for (int b = 1; b < 4; b++) begin
      drive_beat(b);
      step();
    end
    idle_inputs();
    wait_done("stall");
    chk("stall iq_writes", 128'(iq_q.size()), 128'd2);
    if (iq_q.size() == 2) begin
      chk("stall word0", iq_q[0], W_FIRST);
      chk("stall word1", iq_q[1], W_FULL1);
    end
    chk("stall drop_err", 128'(drop_err), 128'd1);

    // Async reset mid-user: partial words discarded, no done, next user from lane 0.
    clear_log();
    start_user(16'd8);
    drive_beat(0);
    noise_strobe = 1'b1;
    noise_data = 16'h0077;
    step();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("arst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) step();
    chk("arst iq_writes", 128'(iq_q.size()), 128'd0);
    chk("arst nz_writes", 128'(nz_q.size()), 128'd0);
    chk("arst done", 128'(done_cnt), 128'd0);
    run_vec(5, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
